// File: rtl/pipeline_interlock_controller_pkg.sv
// Shared types for the pipeline interlock controller: FSM state encodings,
// per-stage control bundle, the NOP instruction and the fixed control patterns.
package pipeline_interlock_controller_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  // ADDI x0,x0,0 loaded by the pipeline registers when flushed or bubbled
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_BOOT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Non-frozen decode: a taken branch squashes the wrong-path load-use stall
  function automatic ctrl_t run_decode(input logic branch_taken, input logic stale);
    ctrl_t c;
    if (branch_taken) begin
      c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    end else if (stale) begin
      c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    end else begin
      c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_interlock_controller_if.sv
// Hazard inputs, per-stage controls and performance counters of the interlock controller.
// master = pipeline datapath side, slave = interlock controller.
interface pipeline_interlock_controller_if #(parameter int PERF_WIDTH = 32);

  logic                  stale;
  logic                  EX_branch_taken;
  logic                  MEM_access;
  logic                  dmem_ready;
  logic                  pc_write;
  logic                  IF_ID_write;
  logic                  IF_ID_flush;
  logic                  ID_EX_bubble;
  logic                  EX_MEM_write;
  logic                  MEM_WB_bubble;
  logic                  mem_timeout;
  logic [PERF_WIDTH-1:0] perf_stall_cnt;
  logic [PERF_WIDTH-1:0] perf_flush_cnt;
  logic [PERF_WIDTH-1:0] perf_wait_cnt;

  modport master (
    output stale, EX_branch_taken, MEM_access, dmem_ready,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble,
    input  mem_timeout, perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
  );

  modport slave (
    input  stale, EX_branch_taken, MEM_access, dmem_ready,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble,
    output mem_timeout, perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
  );

endinterface

// File: rtl/pipeline_interlock_controller_saturating_counter.sv
// Saturating up-counter for interlock performance statistics; only compiled when
// PIPELINE_PERF_COUNTERS_EN is defined, since nothing else instantiates it.
`ifdef PIPELINE_PERF_COUNTERS_EN
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_r;

  // Count enabled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= {WIDTH{1'b0}};
    end else if (inc && (value_r != {WIDTH{1'b1}})) begin
      value_r <= value_r + WIDTH'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule
`endif

// File: rtl/pipeline_interlock_controller.sv
// Load-use / branch / dmem-wait interlock for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPELINE_PERF_COUNTERS_EN is defined.
module pipeline_interlock_controller
  import pipeline_interlock_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 255,
  parameter int WAIT_CNT_WIDTH = 8,
  parameter int PERF_WIDTH     = 32
) (
  input logic                              clk,
  input logic                              rst_n,
  pipeline_interlock_controller_if.slave   bus
);

  localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_C = WAIT_CNT_WIDTH'(MEM_TIMEOUT);

  state_e                    state_r;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_r;
  logic                      mem_timeout_r;
  ctrl_t                     ctrl_s;

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      wait_cnt_r    <= {WAIT_CNT_WIDTH{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.MEM_access && !bus.dmem_ready) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_CNT_WIDTH'(1);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_CNT_WIDTH{1'b0}};
          end else if (wait_cnt_r == TIMEOUT_C) begin
            state_r       <= ST_ERROR;
            mem_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_CNT_WIDTH'(1);
          end
        end
        ST_ERROR: begin
          state_r       <= ST_ERROR;
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r <= ST_BOOT;
        end
      endcase
    end
  end

  // Zero-latency control decode; BOOT pattern also holds throughout reset
  always_comb begin
    ctrl_s = CTRL_FREEZE;
    case (state_r)
      ST_BOOT: begin
        ctrl_s = CTRL_BOOT;
      end
      ST_RUN: begin
        if (bus.MEM_access && !bus.dmem_ready) begin
          ctrl_s = CTRL_FREEZE;
        end else begin
          ctrl_s = run_decode(bus.EX_branch_taken, bus.stale);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          ctrl_s = run_decode(bus.EX_branch_taken, bus.stale);
        end else begin
          ctrl_s = CTRL_FREEZE;
        end
      end
      ST_ERROR: begin
        ctrl_s = CTRL_FREEZE;
      end
      default: begin
        ctrl_s = CTRL_FREEZE;
      end
    endcase
  end

  assign bus.pc_write      = ctrl_s.pc_write;
  assign bus.IF_ID_write   = ctrl_s.if_id_write;
  assign bus.IF_ID_flush   = ctrl_s.if_id_flush;
  assign bus.ID_EX_bubble  = ctrl_s.id_ex_bubble;
  assign bus.EX_MEM_write  = ctrl_s.ex_mem_write;
  assign bus.MEM_WB_bubble = ctrl_s.mem_wb_bubble;
  assign bus.mem_timeout   = mem_timeout_r;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic freeze_s;
  logic decode_s;
  logic stall_ev_s;
  logic flush_ev_s;

  // Events counted whenever the corresponding rule drives the controls
  assign freeze_s   = ((state_r == ST_RUN) && bus.MEM_access && !bus.dmem_ready) ||
                      ((state_r == ST_MEM_WAIT) && !bus.dmem_ready);
  assign decode_s   = ((state_r == ST_RUN) && !(bus.MEM_access && !bus.dmem_ready)) ||
                      ((state_r == ST_MEM_WAIT) && bus.dmem_ready);
  assign flush_ev_s = decode_s && bus.EX_branch_taken;
  assign stall_ev_s = decode_s && !bus.EX_branch_taken && bus.stale;

  saturating_counter #(.WIDTH(PERF_WIDTH)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stall_ev_s), .value(bus.perf_stall_cnt)
  );
  saturating_counter #(.WIDTH(PERF_WIDTH)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush_ev_s), .value(bus.perf_flush_cnt)
  );
  saturating_counter #(.WIDTH(PERF_WIDTH)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .inc(freeze_s), .value(bus.perf_wait_cnt)
  );
`else
  assign bus.perf_stall_cnt = {PERF_WIDTH{1'b0}};
  assign bus.perf_flush_cnt = {PERF_WIDTH{1'b0}};
  assign bus.perf_wait_cnt  = {PERF_WIDTH{1'b0}};
`endif

endmodule
